// File: rtl/drac_hart_reset_sequencer.sv
// Power-up and re-sequence reset gate for a cluster of top_drac harts.
// Harts leave reset one at a time after a wake interval; soft and global resets are layered on top.
module drac_hart_reset_sequencer #(
  parameter int unsigned NUM_HARTS       = 1,
  parameter int unsigned WAKEUP_CYCLES   = 32768,
  parameter int unsigned STAGGER_CYCLES  = 16,
  parameter int unsigned SOFT_RST_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_HARTS-1:0] soft_rst_req_i,
  input  logic                 glb_rst_req_i,
  output logic [NUM_HARTS-1:0] hart_rst_no,
  output logic                 spc_grst_lo,
  output logic [NUM_HARTS-1:0] soft_rst_done_o,
  output logic                 seq_done_o,
  output logic [1:0]           fsm_state
);

  localparam int WW  = $clog2(WAKEUP_CYCLES + 1);
  localparam int SW  = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;
  localparam int SCW = $clog2(SOFT_RST_CYCLES + 1);
  localparam int IW  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  typedef enum logic [1:0] {
    WAKE    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    GHOLD   = 2'd3
  } state_e;

  state_e               state;
  logic [WW-1:0]        wake_cnt;
  logic [SW-1:0]        stg_cnt;
  logic [IW-1:0]        idx;
  logic [SCW-1:0]       hold_cnt;
  logic [SCW-1:0]       soft_cnt [NUM_HARTS];
  logic [NUM_HARTS-1:0] soft_active;

  logic                 glb_take;
  logic                 seq_begin;
  logic [NUM_HARTS-1:0] soft_start;
  logic [NUM_HARTS-1:0] soft_finish;
  logic [NUM_HARTS-1:0] active_next;

  assign fsm_state = state;

  always_comb begin
    glb_take    = glb_rst_req_i && (state == RELEASE || state == RUN);
    seq_begin   = (state == WAKE  && wake_cnt == WW'(WAKEUP_CYCLES - 1)) ||
                  (state == GHOLD && hold_cnt == SCW'(SOFT_RST_CYCLES - 1));
    soft_start  = '0;
    soft_finish = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      soft_finish[h] = soft_active[h] && (soft_cnt[h] == SCW'(SOFT_RST_CYCLES - 1));
      // Outside soft reset every hart is released in RUN, so no separate release check.
      soft_start[h]  = (state == RUN) && !glb_rst_req_i && soft_rst_req_i[h] && !soft_active[h];
    end
    active_next = glb_take ? '0 : ((soft_active & ~soft_finish) | soft_start);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= WAKE;
      wake_cnt        <= '0;
      stg_cnt         <= '0;
      idx             <= '0;
      hold_cnt        <= '0;
      soft_active     <= '0;
      hart_rst_no     <= '0;
      spc_grst_lo     <= 1'b0;
      soft_rst_done_o <= '0;
      seq_done_o      <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) soft_cnt[h] <= '0;
    end else begin
      spc_grst_lo     <= 1'b1;
      soft_rst_done_o <= '0;
      soft_active     <= active_next;

      case (state)
        WAKE:  wake_cnt <= wake_cnt + 1'b1;
        GHOLD: hold_cnt <= hold_cnt + 1'b1;
        RELEASE, RUN: begin
          if (glb_take) begin
            // Cancels in-flight soft resets; their done pulses never fire.
            hart_rst_no <= '0;
            seq_done_o  <= 1'b0;
            hold_cnt    <= '0;
            state       <= GHOLD;
          end else if (state == RELEASE) begin
            if (stg_cnt == SW'(STAGGER_CYCLES - 1)) begin
              stg_cnt <= '0;
              idx     <= idx + 1'b1;
              for (int h = 0; h < NUM_HARTS; h++)
                if (idx == IW'(h)) hart_rst_no[h] <= 1'b1;
              if (idx == IW'(NUM_HARTS - 1)) begin
                state      <= RUN;
                seq_done_o <= 1'b1;
              end
            end else begin
              stg_cnt <= stg_cnt + 1'b1;
            end
          end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
              if (soft_start[h]) begin
                hart_rst_no[h] <= 1'b0;
                soft_cnt[h]    <= '0;
              end else if (soft_finish[h]) begin
                hart_rst_no[h]     <= 1'b1;
                soft_rst_done_o[h] <= 1'b1;
              end else if (soft_active[h]) begin
                soft_cnt[h] <= soft_cnt[h] + 1'b1;
              end
            end
            seq_done_o <= ~|active_next;
          end
        end
        default: state <= WAKE;
      endcase

      // Shared by the end of WAKE and the end of GHOLD: hart 0 goes first.
      if (seq_begin) begin
        stg_cnt <= '0;
        idx     <= IW'(1);
        if (STAGGER_CYCLES == 0 || NUM_HARTS == 1) begin
          hart_rst_no <= '1;
          seq_done_o  <= 1'b1;
          state       <= RUN;
        end else begin
          hart_rst_no[0] <= 1'b1;
          state          <= RELEASE;
        end
      end
    end
  end

endmodule

// File: tb/tb_drac_hart_reset_sequencer.sv
// Bench for drac_hart_reset_sequencer: power-up vector table, soft/global/async corner sequences,
// and a randomized run scored against an edge-time model of the release rules.
module tb_drac_hart_reset_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int SR = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] soft_req = '0;
  logic         glb_req = 1'b0;

  logic [N-1:0] hart_rst_n, done;
  logic         spc, seq_done;
  logic [1:0]   fsm_state;
  logic [N-1:0] hart_rst_n_s0, done_s0;
  logic         spc_s0, seq_done_s0;
  logic [1:0]   fsm_state_s0;

  always #5 clk = ~clk;

  drac_hart_reset_sequencer #(
    .NUM_HARTS(N), .WAKEUP_CYCLES(W), .STAGGER_CYCLES(S), .SOFT_RST_CYCLES(SR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .soft_rst_req_i(soft_req), .glb_rst_req_i(glb_req),
    .hart_rst_no(hart_rst_n), .spc_grst_lo(spc), .soft_rst_done_o(done),
    .seq_done_o(seq_done), .fsm_state(fsm_state)
  );

  drac_hart_reset_sequencer #(
    .NUM_HARTS(N), .WAKEUP_CYCLES(W), .STAGGER_CYCLES(0), .SOFT_RST_CYCLES(SR)
  ) dut_s0 (
    .clk_i(clk), .rst_ni(rst_n), .soft_rst_req_i(soft_req), .glb_rst_req_i(glb_req),
    .hart_rst_no(hart_rst_n_s0), .spc_grst_lo(spc_s0), .soft_rst_done_o(done_s0),
    .seq_done_o(seq_done_s0), .fsm_state(fsm_state_s0)
  );

  int checks = 0;
  int errors = 0;

  // Model: k = edges since reset release, base = edge releasing hart 0,
  // soft_end[h] = edge at which hart h leaves its soft reset (0 = none).
  int           k;
  int           base;
  int           soft_end [N];
  logic [9:0]   exp_q [$];

  typedef struct {
    int         edge_k;
    logic [3:0] hart;
    logic       seq;
    logic [3:0] hart0;
    logic       seq0;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    k    = 0;
    base = W;
    for (int h = 0; h < N; h++) soft_end[h] = 0;
  endtask

  task automatic model_edge(input logic g, input logic [N-1:0] s);
    int         p;
    int         last;
    logic [N-1:0] hart_e;
    logic [N-1:0] done_e;
    logic       any_soft;
    logic       seq_e;
    k++;
    p    = k - 1;
    last = base + (N - 1) * S;
    done_e = '0;
    for (int h = 0; h < N; h++) if (soft_end[h] == k) done_e[h] = 1'b1;
    if (g && p >= base) begin
      base = k + SR;
      for (int h = 0; h < N; h++) soft_end[h] = 0;
      done_e = '0;
    end else if (p >= last) begin
      for (int h = 0; h < N; h++)
        if (s[h] && soft_end[h] < k) soft_end[h] = k + SR;
    end
    last     = base + (N - 1) * S;
    any_soft = 1'b0;
    for (int h = 0; h < N; h++) begin
      hart_e[h] = (k >= base + h * S) && !(soft_end[h] > k);
      if (soft_end[h] > k) any_soft = 1'b1;
    end
    seq_e = (k >= last) && !any_soft;
    exp_q.push_back({hart_e, done_e, seq_e, 1'b1});
  endtask

  task automatic step(input logic g, input logic [N-1:0] s);
    logic [9:0] e;
    glb_req  = g;
    soft_req = s;
    @(posedge clk);
    model_edge(g, s);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("sb_e%0d", k), 32'({hart_rst_n, done, seq_done, spc}), 32'(e));
  endtask

  // Drops rst_ni #1 after an edge, checks the immediate clear, releases at the next negedge.
  task automatic apply_reset();
    rst_n    = 1'b0;
    glb_req  = 1'b0;
    soft_req = '0;
    #1;
    chk("rst_main", 32'({hart_rst_n, done, seq_done, spc}), 32'd0);
    chk("rst_s0", 32'({hart_rst_n_s0, done_s0, seq_done_s0, spc_s0}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input logic noise);
    for (int i = 0; i < 10; i++) begin
      while (k < tbl[i].edge_k) begin
        if (noise && k + 1 <= 7) step(1'b1, 4'b1111);
        else step(1'b0, 4'b0000);
      end
      chk($sformatf("tbl_hart_e%0d", k), 32'(hart_rst_n), 32'(tbl[i].hart));
      chk($sformatf("tbl_seq_e%0d", k), 32'(seq_done), 32'(tbl[i].seq));
      chk($sformatf("tbl_spc_e%0d", k), 32'(spc), 32'd1);
      chk($sformatf("tbl_s0_hart_e%0d", k), 32'(hart_rst_n_s0), 32'(tbl[i].hart0));
      chk($sformatf("tbl_s0_seq_e%0d", k), 32'(seq_done_s0), 32'(tbl[i].seq0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,  4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{7,  4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[2] = '{8,  4'b0001, 1'b0, 4'b1111, 1'b1};
    tbl[3] = '{9,  4'b0001, 1'b0, 4'b1111, 1'b1};
    tbl[4] = '{10, 4'b0011, 1'b0, 4'b1111, 1'b1};
    tbl[5] = '{11, 4'b0011, 1'b0, 4'b1111, 1'b1};
    tbl[6] = '{12, 4'b0111, 1'b0, 4'b1111, 1'b1};
    tbl[7] = '{13, 4'b0111, 1'b0, 4'b1111, 1'b1};
    tbl[8] = '{14, 4'b1111, 1'b1, 4'b1111, 1'b1};
    tbl[9] = '{15, 4'b1111, 1'b1, 4'b1111, 1'b1};

    apply_reset();
    run_table(1'b0);

    // Soft reset of hart 2 at edge 20, repeated at 21 without extending it.
    while (k < 19) step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    chk("soft_hart_e20", 32'(hart_rst_n), 32'(4'b1011));
    chk("soft_seq_e20", 32'(seq_done), 32'd0);
    step(1'b0, 4'b0100);
    chk("soft_hart_e21", 32'(hart_rst_n), 32'(4'b1011));
    step(1'b0, 4'b0000);
    chk("soft_hart_e22", 32'(hart_rst_n), 32'(4'b1011));
    chk("soft_seq_e22", 32'(seq_done), 32'd0);
    step(1'b0, 4'b0000);
    chk("soft_hart_e23", 32'(hart_rst_n), 32'(4'b1111));
    chk("soft_done_e23", 32'(done), 32'(4'b0100));
    step(1'b0, 4'b0000);
    chk("soft_done_e24", 32'(done), 32'd0);
    chk("soft_seq_e24", 32'(seq_done), 32'd1);

    // Global reset at 30 while hart 1 is mid soft reset.
    while (k < 28) step(1'b0, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b1, 4'b0000);
    chk("glb_hart_e30", 32'(hart_rst_n), 32'd0);
    chk("glb_seq_e30", 32'(seq_done), 32'd0);
    while (k < 40) begin
      step(1'b0, 4'b0000);
      chk($sformatf("glb_nodone_e%0d", k), 32'(done), 32'd0);
      case (k)
        32: chk("glb_hart_e32", 32'(hart_rst_n), 32'(4'b0000));
        33: chk("glb_hart_e33", 32'(hart_rst_n), 32'(4'b0001));
        35: chk("glb_hart_e35", 32'(hart_rst_n), 32'(4'b0011));
        37: chk("glb_hart_e37", 32'(hart_rst_n), 32'(4'b0111));
        39: begin
          chk("glb_hart_e39", 32'(hart_rst_n), 32'(4'b1111));
          chk("glb_seq_e39", 32'(seq_done), 32'd1);
        end
        default: ;
      endcase
    end

    // Async reset between edges 10 and 11, then a full restart.
    apply_reset();
    while (k < 10) step(1'b0, 4'b0000);
    apply_reset();
    run_table(1'b0);

    // Requests held through WAKE must not disturb the timing.
    apply_reset();
    run_table(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic       g;
      logic [N-1:0] s;
      g = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 299) == 0) apply_reset();
      step(g, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
